// File: rtl/spu_issue_pkg.sv
// Shared types, opcode constants and field positions for the SPU dual-issue stage.
// Field positions are vector indices; the ISA numbers bit 0 as the MSB, so ISA bit n is index 31-n.
package spu_issue_pkg;

    localparam int PC_W    = 9;
    localparam int INSTR_W = 32;
    localparam int REG_W   = 7;

    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } pipe_e;

    typedef enum logic {
        PAIR   = 1'b0,
        SECOND = 1'b1
    } state_e;

    localparam logic [10:0] OP_NOP  = 11'b01000000001;
    localparam logic [10:0] OP_LNOP = 11'b00000000001;
    localparam logic [10:0] OP_A    = 11'b00011000000;
    localparam logic [7:0]  OP_LQD  = 8'b00110100;

    // ISA [0:10] / [0:7] opcode, [11:17] rb, [18:24] ra, [25:31] rt and rc
    localparam int OP11_LSB = 21;
    localparam int OP8_LSB  = 24;
    localparam int RB_LSB   = 14;
    localparam int RA_LSB   = 7;
    localparam int RT_LSB   = 0;
    localparam int RC_LSB   = 0;

    typedef struct packed {
        pipe_e             pipe;
        logic              writesRt;
        logic [REG_W-1:0]  rt;
        logic              raValid;
        logic [REG_W-1:0]  ra;
        logic              rbValid;
        logic [REG_W-1:0]  rb;
        logic              rcValid;
        logic [REG_W-1:0]  rc;
    } decode_t;

    function automatic logic rawHazard(decode_t older, decode_t younger);
        logic hit;
        hit = (younger.raValid && (younger.ra == older.rt)) ||
              (younger.rbValid && (younger.rb == older.rt)) ||
              (younger.rcValid && (younger.rc == older.rt));
        return older.writesRt && hit;
    endfunction

endpackage

// File: rtl/spu_issue_stage_if.sv
// Fetch-to-issue and issue-to-pipe signal bundle for spu_issue_stage.
interface spu_issue_stage_if;
    import spu_issue_pkg::*;

    logic [INSTR_W-1:0] instr1_in;
    logic [INSTR_W-1:0] instr2_in;
    logic [PC_W-1:0]    pc_in;
    logic               find_nop;
    logic               flush;
    logic               ext_stall;
    logic               stall_out;
    logic [INSTR_W-1:0] even_instr;
    logic               even_valid;
    logic [PC_W-1:0]    even_pc;
    logic [INSTR_W-1:0] odd_instr;
    logic               odd_valid;
    logic [PC_W-1:0]    odd_pc;

    modport master (
        output instr1_in, instr2_in, pc_in, find_nop, flush, ext_stall,
        input  stall_out, even_instr, even_valid, even_pc, odd_instr, odd_valid, odd_pc
    );

    modport slave (
        input  instr1_in, instr2_in, pc_in, find_nop, flush, ext_stall,
        output stall_out, even_instr, even_valid, even_pc, odd_instr, odd_valid, odd_pc
    );

endinterface

// File: rtl/spu_pipe_classify.sv
// Combinational opcode decode: pipe class, destination and source register fields.
module spu_pipe_classify
    import spu_issue_pkg::*;
(
    input  logic [INSTR_W-1:0] instr_i,
    output decode_t            dec_o
);

    logic [10:0] op11;
    logic [7:0]  op8;

    assign op11 = instr_i[OP11_LSB +: 11];
    assign op8  = instr_i[OP8_LSB +: 8];

    // Unknown opcodes fall back to even with no register dependencies
    always_comb begin
        dec_o      = '0;
        dec_o.pipe = EVEN;
        dec_o.rt   = instr_i[RT_LSB +: REG_W];
        dec_o.ra   = instr_i[RA_LSB +: REG_W];
        dec_o.rb   = instr_i[RB_LSB +: REG_W];
        dec_o.rc   = instr_i[RC_LSB +: REG_W];
        if (op11 == OP_A) begin
            dec_o.pipe     = EVEN;
            dec_o.writesRt = 1'b1;
            dec_o.raValid  = 1'b1;
            dec_o.rbValid  = 1'b1;
        end else if (op11 == OP_NOP) begin
            dec_o.pipe = EVEN;
        end else if (op11 == OP_LNOP) begin
            dec_o.pipe = ODD;
        end else if (op8 == OP_LQD) begin
            dec_o.pipe     = ODD;
            dec_o.writesRt = 1'b1;
            dec_o.raValid  = 1'b1;
        end
    end

endmodule

// File: rtl/spu_issue_stage.sv
// SPU dual-issue stage: routes a fetched pair to the even/odd pipes or splits it over two cycles.
// Optional SPU_ISSUE_STATS_EN adds saturating dual/single/stall event counters.
module spu_issue_stage
    import spu_issue_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    spu_issue_stage_if.slave   bus
`ifdef SPU_ISSUE_STATS_EN
    ,
    output logic [31:0]        dual_cnt,
    output logic [31:0]        single_cnt,
    output logic [31:0]        stall_cnt
`endif
);

    decode_t dec1;
    decode_t dec2;

    spu_pipe_classify uClassify1 (
        .instr_i (bus.instr1_in),
        .dec_o   (dec1)
    );

    spu_pipe_classify uClassify2 (
        .instr_i (bus.instr2_in),
        .dec_o   (dec2)
    );

    state_e             state_q,      state_d;
    logic [INSTR_W-1:0] holdInstr_q,  holdInstr_d;
    logic [PC_W-1:0]    holdPc_q,     holdPc_d;
    pipe_e              holdPipe_q,   holdPipe_d;
    logic               holdValid_q,  holdValid_d;
    logic [INSTR_W-1:0] evenInstr_q,  evenInstr_d;
    logic [PC_W-1:0]    evenPc_q,     evenPc_d;
    logic               evenValid_q,  evenValid_d;
    logic [INSTR_W-1:0] oddInstr_q,   oddInstr_d;
    logic [PC_W-1:0]    oddPc_q,      oddPc_d;
    logic               oddValid_q,   oddValid_d;

    logic               bubble1;
    logic               bubble2;
    logic               split;
    logic [PC_W-1:0]    pc2;
    logic               stallComb;
    logic               advance;

    // Candidate issues for this cycle, before routing onto the pipes
    logic               iss1Valid, iss2Valid;
    logic [INSTR_W-1:0] iss1Instr, iss2Instr;
    logic [PC_W-1:0]    iss1Pc,    iss2Pc;
    pipe_e              iss1Pipe,  iss2Pipe;

    assign bubble1 = (bus.instr1_in == '0) || bus.find_nop;
    assign bubble2 = (bus.instr2_in == '0);
    assign pc2     = bus.pc_in + PC_W'(1);

    // Only an even-then-odd pair with no RAW dependency may dual-issue
    assign split = !bubble1 && !bubble2 &&
                   ((dec1.pipe == dec2.pipe) ||
                    (dec1.pipe == ODD && dec2.pipe == EVEN) ||
                    rawHazard(dec1, dec2));

    assign advance = !bus.flush && !bus.ext_stall;

    always_comb begin
        iss1Valid   = 1'b0;
        iss1Instr   = '0;
        iss1Pc      = '0;
        iss1Pipe    = EVEN;
        iss2Valid   = 1'b0;
        iss2Instr   = '0;
        iss2Pc      = '0;
        iss2Pipe    = EVEN;
        state_d     = state_q;
        holdInstr_d = holdInstr_q;
        holdPc_d    = holdPc_q;
        holdPipe_d  = holdPipe_q;
        holdValid_d = holdValid_q;
        stallComb   = 1'b0;

        if (bus.flush) begin
            state_d     = PAIR;
            holdValid_d = 1'b0;
        end else if (bus.ext_stall) begin
            stallComb = 1'b1;
        end else if (state_q == SECOND) begin
            iss1Valid   = holdValid_q;
            iss1Instr   = holdInstr_q;
            iss1Pc      = holdPc_q;
            iss1Pipe    = holdPipe_q;
            holdValid_d = 1'b0;
            state_d     = PAIR;
        end else begin
            iss1Valid = !bubble1;
            iss1Instr = bus.instr1_in;
            iss1Pc    = bus.pc_in;
            iss1Pipe  = dec1.pipe;
            if (split) begin
                holdInstr_d = bus.instr2_in;
                holdPc_d    = pc2;
                holdPipe_d  = dec2.pipe;
                holdValid_d = 1'b1;
                state_d     = SECOND;
                stallComb   = 1'b1;
            end else begin
                iss2Valid = !bubble2;
                iss2Instr = bus.instr2_in;
                iss2Pc    = pc2;
                iss2Pipe  = dec2.pipe;
            end
        end
    end

    // Frozen under ext_stall; otherwise rebuilt from the candidates, with unused pipes zeroed
    always_comb begin
        evenInstr_d = evenInstr_q;
        evenPc_d    = evenPc_q;
        evenValid_d = evenValid_q;
        oddInstr_d  = oddInstr_q;
        oddPc_d     = oddPc_q;
        oddValid_d  = oddValid_q;
        if (bus.flush || !bus.ext_stall) begin
            evenInstr_d = '0;
            evenPc_d    = '0;
            evenValid_d = 1'b0;
            oddInstr_d  = '0;
            oddPc_d     = '0;
            oddValid_d  = 1'b0;
            if (iss1Valid && iss1Pipe == EVEN) begin
                evenInstr_d = iss1Instr;
                evenPc_d    = iss1Pc;
                evenValid_d = 1'b1;
            end else if (iss2Valid && iss2Pipe == EVEN) begin
                evenInstr_d = iss2Instr;
                evenPc_d    = iss2Pc;
                evenValid_d = 1'b1;
            end
            if (iss1Valid && iss1Pipe == ODD) begin
                oddInstr_d = iss1Instr;
                oddPc_d    = iss1Pc;
                oddValid_d = 1'b1;
            end else if (iss2Valid && iss2Pipe == ODD) begin
                oddInstr_d = iss2Instr;
                oddPc_d    = iss2Pc;
                oddValid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PAIR;
            holdInstr_q <= '0;
            holdPc_q    <= '0;
            holdPipe_q  <= EVEN;
            holdValid_q <= 1'b0;
            evenInstr_q <= '0;
            evenPc_q    <= '0;
            evenValid_q <= 1'b0;
            oddInstr_q  <= '0;
            oddPc_q     <= '0;
            oddValid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            holdInstr_q <= holdInstr_d;
            holdPc_q    <= holdPc_d;
            holdPipe_q  <= holdPipe_d;
            holdValid_q <= holdValid_d;
            evenInstr_q <= evenInstr_d;
            evenPc_q    <= evenPc_d;
            evenValid_q <= evenValid_d;
            oddInstr_q  <= oddInstr_d;
            oddPc_q     <= oddPc_d;
            oddValid_q  <= oddValid_d;
        end
    end

    assign bus.stall_out  = stallComb && !rst;
    assign bus.even_instr = evenInstr_q;
    assign bus.even_pc    = evenPc_q;
    assign bus.even_valid = evenValid_q;
    assign bus.odd_instr  = oddInstr_q;
    assign bus.odd_pc     = oddPc_q;
    assign bus.odd_valid  = oddValid_q;

`ifdef SPU_ISSUE_STATS_EN
    logic [31:0] dualCnt_q,   dualCnt_d;
    logic [31:0] singleCnt_q, singleCnt_d;
    logic [31:0] stallCnt_q,  stallCnt_d;

    always_comb begin
        dualCnt_d   = dualCnt_q;
        singleCnt_d = singleCnt_q;
        stallCnt_d  = stallCnt_q;
        if (advance && evenValid_d && oddValid_d && dualCnt_q != 32'hFFFF_FFFF) begin
            dualCnt_d = dualCnt_q + 32'd1;
        end
        if (advance && (evenValid_d != oddValid_d) && singleCnt_q != 32'hFFFF_FFFF) begin
            singleCnt_d = singleCnt_q + 32'd1;
        end
        if (bus.stall_out && stallCnt_q != 32'hFFFF_FFFF) begin
            stallCnt_d = stallCnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dualCnt_q   <= '0;
            singleCnt_q <= '0;
            stallCnt_q  <= '0;
        end else begin
            dualCnt_q   <= dualCnt_d;
            singleCnt_q <= singleCnt_d;
            stallCnt_q  <= stallCnt_d;
        end
    end

    assign dual_cnt   = dualCnt_q;
    assign single_cnt = singleCnt_q;
    assign stall_cnt  = stallCnt_q;
`else
    logic unusedAdvance;
    assign unusedAdvance = advance;
`endif

endmodule

// File: tb/tb_spu_issue_stage.sv
// Self-checking bench for spu_issue_stage: directed plan steps, then random pairs against an issue-list model.
module tb_spu_issue_stage;

    localparam logic [10:0] TB_NOP  = 11'b01000000001;
    localparam logic [10:0] TB_LNOP = 11'b00000000001;
    localparam logic [10:0] TB_A    = 11'b00011000000;
    localparam logic [7:0]  TB_LQD  = 8'b00110100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spu_issue_stage_if bus ();

`ifdef SPU_ISSUE_STATS_EN
    logic [31:0] dualCnt, singleCnt, stallCnt;
`endif

    spu_issue_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef SPU_ISSUE_STATS_EN
        ,
        .dual_cnt   (dualCnt),
        .single_cnt (singleCnt),
        .stall_cnt  (stallCnt)
`endif
    );

    int assertCount = 0;
    int failCount   = 0;

    // Model state: a pending second-half instruction and the expected pipe registers
    bit          mPending = 1'b0;
    logic [31:0] mHeldInstr = '0;
    logic [8:0]  mHeldPc = '0;
    logic [31:0] eEvenI = '0, eOddI = '0;
    logic [8:0]  eEvenP = '0, eOddP = '0;
    logic        eEvenV = 1'b0, eOddV = 1'b0;
    logic        eStall = 1'b0;

    function automatic logic [31:0] mkA(int rt, int ra, int rb);
        return {TB_A, 7'(rb), 7'(ra), 7'(rt)};
    endfunction

    function automatic logic [31:0] mkLqd(int rt, int ra, int imm);
        return {TB_LQD, 10'(imm), 7'(ra), 7'(rt)};
    endfunction

    function automatic bit isOdd(logic [31:0] w);
        return (w[31:21] == TB_LNOP) || (w[31:24] == TB_LQD);
    endfunction

    function automatic bit readsReg(logic [31:0] w, logic [6:0] r);
        if (w[31:21] == TB_A)  return (w[13:7] == r) || (w[20:14] == r);
        if (w[31:24] == TB_LQD) return (w[13:7] == r);
        return 1'b0;
    endfunction

    function automatic bit writesReg(logic [31:0] w);
        return (w[31:21] == TB_A) || (w[31:24] == TB_LQD);
    endfunction

    function automatic logic [31:0] randInstr();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return {TB_NOP, 21'($urandom)};
            2:       return {TB_LNOP, 21'($urandom)};
            3, 4:    return mkA($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            default: return mkLqd($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1023));
        endcase
    endfunction

    task automatic checkVal(string tag, logic [31:0] obs, logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkVal("even_valid", 32'(bus.even_valid), 32'(eEvenV));
        checkVal("even_instr", bus.even_instr, eEvenI);
        checkVal("even_pc", 32'(bus.even_pc), 32'(eEvenP));
        checkVal("odd_valid", 32'(bus.odd_valid), 32'(eOddV));
        checkVal("odd_instr", bus.odd_instr, eOddI);
        checkVal("odd_pc", 32'(bus.odd_pc), 32'(eOddP));
    endtask

    // Drives one cycle of inputs, predicts from the issue rules, checks stall_out then the registers
    task automatic applyStimulus(logic r, logic fl, logic st, logic fn,
                                 logic [31:0] i1, logic [31:0] i2, logic [8:0] pc);
        logic [31:0] issI[$];
        logic [8:0]  issP[$];
        logic [8:0]  pcNext;
        bit          b1, b2, doSplit;
        rst           = r;
        bus.flush     = fl;
        bus.ext_stall = st;
        bus.find_nop  = fn;
        bus.instr1_in = i1;
        bus.instr2_in = i2;
        bus.pc_in     = pc;
        pcNext        = pc + 9'd1;
        if (r || fl) begin
            mPending = 1'b0;
            eStall   = 1'b0;
            {eEvenV, eEvenI, eEvenP, eOddV, eOddI, eOddP} = '0;
        end else if (st) begin
            eStall = 1'b1;
        end else begin
            eStall = 1'b0;
            if (mPending) begin
                issI.push_back(mHeldInstr);
                issP.push_back(mHeldPc);
                mPending = 1'b0;
            end else begin
                b1 = (i1 == 32'h0) || fn;
                b2 = (i2 == 32'h0);
                doSplit = 1'b0;
                if (!b1 && !b2) begin
                    doSplit = (isOdd(i1) == isOdd(i2)) || (isOdd(i1) && !isOdd(i2)) ||
                              (writesReg(i1) && readsReg(i2, i1[6:0]));
                end
                if (!b1) begin
                    issI.push_back(i1);
                    issP.push_back(pc);
                end
                if (doSplit) begin
                    mPending   = 1'b1;
                    mHeldInstr = i2;
                    mHeldPc    = pcNext;
                    eStall     = 1'b1;
                end else if (!b2) begin
                    issI.push_back(i2);
                    issP.push_back(pcNext);
                end
            end
            {eEvenV, eEvenI, eEvenP, eOddV, eOddI, eOddP} = '0;
            foreach (issI[k]) begin
                if (isOdd(issI[k])) begin
                    eOddV = 1'b1; eOddI = issI[k]; eOddP = issP[k];
                end else begin
                    eEvenV = 1'b1; eEvenI = issI[k]; eEvenP = issP[k];
                end
            end
        end
        #1;
        checkVal("stall_out", 32'(bus.stall_out), 32'(eStall));
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        logic [31:0] aa, ab, lq;
        aa = mkA(3, 1, 2);
        ab = mkA(4, 5, 6);
        lq = mkLqd(5, 1, 16);

        $display("[TB] reset");
        applyStimulus(1'b1, 0, 0, 0, 32'h0, 32'h0, 9'd0);
        applyStimulus(1'b1, 0, 0, 0, aa, lq, 9'd0);

        $display("[TB] dual issue A+LQD at pc 4");
        applyStimulus(0, 0, 0, 0, aa, lq, 9'd4);
        checkVal("plan_even_pc4", 32'(bus.even_pc), 32'd4);
        checkVal("plan_odd_pc5", 32'(bus.odd_pc), 32'd5);

        $display("[TB] A,A split at pc 8 with replay");
        applyStimulus(0, 0, 0, 0, aa, ab, 9'd8);
        applyStimulus(0, 0, 0, 0, aa, ab, 9'd8);
        checkVal("plan_second_pc9", 32'(bus.even_pc), 32'd9);

        $display("[TB] LQD,A reorder split and RAW split");
        applyStimulus(0, 0, 0, 0, lq, aa, 9'd30);
        applyStimulus(0, 0, 0, 0, lq, aa, 9'd30);
        applyStimulus(0, 0, 0, 0, mkA(7, 1, 2), mkLqd(5, 7, 0), 9'd40);
        applyStimulus(0, 0, 0, 0, mkA(7, 1, 2), mkLqd(5, 7, 0), 9'd40);

        $display("[TB] bubbles");
        applyStimulus(0, 0, 0, 1, aa, {TB_LNOP, 21'h0}, 9'd10);
        checkVal("plan_findnop_pc11", 32'(bus.odd_pc), 32'd11);
        applyStimulus(0, 0, 0, 0, 32'h0, aa, 9'd20);
        applyStimulus(0, 0, 0, 0, lq, 32'h0, 9'd22);
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 9'd24);

        $display("[TB] pc wrap");
        applyStimulus(0, 0, 0, 0, aa, lq, 9'd511);

        $display("[TB] ext_stall during SECOND");
        applyStimulus(0, 0, 0, 0, aa, ab, 9'd50);
        for (int n = 0; n < 3; n++) applyStimulus(0, 0, 1, 0, aa, ab, 9'd50);
        applyStimulus(0, 0, 0, 0, aa, ab, 9'd50);

        $display("[TB] flush with ext_stall in SECOND, then replay");
        applyStimulus(0, 0, 0, 0, aa, ab, 9'd60);
        applyStimulus(0, 1, 1, 0, aa, ab, 9'd60);
        applyStimulus(0, 0, 0, 0, aa, ab, 9'd60);
        applyStimulus(0, 0, 0, 0, aa, ab, 9'd60);

        $display("[TB] reset mid-split");
        applyStimulus(0, 0, 0, 0, lq, lq, 9'd70);
        applyStimulus(1, 0, 0, 0, lq, lq, 9'd70);
        applyStimulus(0, 0, 0, 0, aa, lq, 9'd72);

        $display("[TB] random pairs");
        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 19) == 0),
                          ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                          randInstr(), randInstr(), 9'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
